// File: rtl/cam_pattern_tx.sv
// rtl/cam_pattern_tx.sv - synthetic OV7670-style RGB565 test-pattern transmitter
// Counters hold the state of the byte being shown; outputs are registered from next-state values.
module cam_pattern_tx #(
  parameter int H_ACTIVE   = 160,
  parameter int V_ACTIVE   = 120,
  parameter int H_BLANK    = 16,
  parameter int VSYNC_CYC  = 32,
  parameter int VFRONT_CYC = 64,
  parameter int VBACK_CYC  = 64
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VSYNC  = 3'd1;
  localparam logic [2:0] VFRONT = 3'd2;
  localparam logic [2:0] LINE   = 3'd3;
  localparam logic [2:0] HBLANK = 3'd4;
  localparam logic [2:0] VBACK  = 3'd5;

  localparam logic [15:0] VSYNC_LAST  = 16'(VSYNC_CYC - 1);
  localparam logic [15:0] VFRONT_LAST = 16'(VFRONT_CYC - 1);
  localparam logic [15:0] LINE_LAST   = 16'(2 * H_ACTIVE - 1);
  localparam logic [15:0] HBLANK_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VBACK_LAST  = 16'(VBACK_CYC - 1);
  localparam logic [15:0] Y_LAST      = 16'(V_ACTIVE - 1);
  localparam logic [15:0] BAR_LAST    = 16'(H_ACTIVE / 8 - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        phase_q, phase_d;
  logic [2:0]  bar_q, bar_d;
  logic [15:0] bar_cnt_q, bar_cnt_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] solid_q, solid_d;
  logic [4:0]  ramp_b_q, ramp_b_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        vsync_q, href_q, frame_done_q;
  logic [7:0]  d_q, byte_d;
  logic [15:0] pix;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    y_d         = y_q;
    pat_d       = pat_q;
    solid_d     = solid_q;
    ramp_b_d    = ramp_b_q;
    frame_cnt_d = frame_cnt_q;
    // Outside LINE the horizontal counters sit at zero, so every line starts clean.
    x_d         = 16'd0;
    phase_d     = 1'b0;
    bar_d       = 3'd0;
    bar_cnt_d   = 16'd0;

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (enable) begin
          state_d  = VSYNC;
          pat_d    = pattern_sel;
          solid_d  = solid_rgb;
          ramp_b_d = frame_cnt_q[4:0];
        end
      end
      VSYNC: begin
        if (cnt_q == VSYNC_LAST) begin
          state_d = VFRONT;
          cnt_d   = 16'd0;
        end
      end
      VFRONT: begin
        if (cnt_q == VFRONT_LAST) begin
          state_d = LINE;
          cnt_d   = 16'd0;
          y_d     = 16'd0;
        end
      end
      LINE: begin
        phase_d   = ~phase_q;
        x_d       = x_q;
        bar_d     = bar_q;
        bar_cnt_d = bar_cnt_q;
        if (phase_q) begin
          x_d = x_q + 16'd1;
          if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = 16'd0;
            bar_d     = bar_q + 3'd1;
          end else begin
            bar_cnt_d = bar_cnt_q + 16'd1;
          end
        end
        if (cnt_q == LINE_LAST) begin
          state_d = HBLANK;
          cnt_d   = 16'd0;
        end
      end
      HBLANK: begin
        if (cnt_q == HBLANK_LAST) begin
          cnt_d = 16'd0;
          if (y_q < Y_LAST) begin
            y_d     = y_q + 16'd1;
            state_d = LINE;
          end else begin
            state_d = VBACK;
          end
        end
      end
      VBACK: begin
        if (cnt_q == VBACK_LAST) begin
          cnt_d       = 16'd0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (enable) begin
            state_d  = VSYNC;
            pat_d    = pattern_sel;
            solid_d  = solid_rgb;
            ramp_b_d = frame_cnt_d[4:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_comb begin
    pix = 16'h0000;
    case (pat_d)
      2'd0:    pix = {{5{bar_d[2]}}, {6{bar_d[1]}}, {5{bar_d[0]}}};
      2'd1:    pix = {x_d[4:0], y_d[5:0], ramp_b_d};
      2'd2:    pix = solid_d;
      default: pix = (x_d[3] ^ y_d[3]) ? 16'hFFFF : 16'h0000;
    endcase
    byte_d = phase_d ? pix[7:0] : pix[15:8];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      phase_q      <= 1'b0;
      bar_q        <= 3'd0;
      bar_cnt_q    <= 16'd0;
      pat_q        <= 2'd0;
      solid_q      <= 16'd0;
      ramp_b_q     <= 5'd0;
      frame_cnt_q  <= 8'd0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      d_q          <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      bar_q        <= bar_d;
      bar_cnt_q    <= bar_cnt_d;
      pat_q        <= pat_d;
      solid_q      <= solid_d;
      ramp_b_q     <= ramp_b_d;
      frame_cnt_q  <= frame_cnt_d;
      vsync_q      <= (state_d == VSYNC);
      href_q       <= (state_d == LINE);
      d_q          <= (state_d == LINE) ? byte_d : 8'h00;
      frame_done_q <= (state_d == VBACK) && (cnt_d == VBACK_LAST);
    end
  end

  assign vsync      = vsync_q;
  assign href       = href_q;
  assign d          = d_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cam_pattern_tx.sv
// tb/tb_cam_pattern_tx.sv - scoreboard bench for cam_pattern_tx
// Expected per-cycle output tuples are queued at frame start; a monitor pops one per cycle.
module tb_cam_pattern_tx;

  localparam int H_ACTIVE   = 16;
  localparam int V_ACTIVE   = 12;
  localparam int H_BLANK    = 2;
  localparam int VSYNC_CYC  = 3;
  localparam int VFRONT_CYC = 2;
  localparam int VBACK_CYC  = 2;
  localparam int FRAME_LEN  = VSYNC_CYC + VFRONT_CYC + V_ACTIVE * (2 * H_ACTIVE + H_BLANK) + VBACK_CYC;

  logic        pclk = 1'b0;
  logic        rst_n, enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb;
  logic        vsync, href, frame_done;
  logic [7:0]  d, frame_cnt;

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] d;
    logic       fd;
    logic [7:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   fidx = 0;
  bit   to_flag = 1'b0;

  cam_pattern_tx #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_CYC(VSYNC_CYC), .VFRONT_CYC(VFRONT_CYC), .VBACK_CYC(VBACK_CYC)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .vsync(vsync), .href(href), .d(d),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  function automatic logic [15:0] ref_pix(int x, int y, int k, logic [1:0] pat, logic [15:0] sol);
    int b, r, g, bl;
    case (pat)
      2'd0: begin
        b  = x / (H_ACTIVE / 8);
        r  = ((b / 4) % 2) ? 31 : 0;
        g  = ((b / 2) % 2) ? 63 : 0;
        bl = (b % 2) ? 31 : 0;
        return 16'(r * 2048 + g * 32 + bl);
      end
      2'd1:    return 16'((x % 32) * 2048 + (y % 64) * 32 + (k % 32));
      2'd2:    return sol;
      default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  function automatic exp_t mk(logic vs, logic hr, logic [7:0] dd, logic fd, int k);
    exp_t e;
    e.vs = vs; e.hr = hr; e.d = dd; e.fd = fd; e.fc = 8'(k);
    return e;
  endfunction

  task automatic push_frame(int k, logic [1:0] pat, logic [15:0] sol);
    logic [15:0] p;
    for (int i = 0; i < VSYNC_CYC; i++) exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, k));
    for (int i = 0; i < VFRONT_CYC; i++) exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, k));
    for (int y = 0; y < V_ACTIVE; y++) begin
      for (int x = 0; x < H_ACTIVE; x++) begin
        p = ref_pix(x, y, k, pat, sol);
        exp_q.push_back(mk(1'b0, 1'b1, p[15:8], 1'b0, k));
        exp_q.push_back(mk(1'b0, 1'b1, p[7:0], 1'b0, k));
      end
      for (int i = 0; i < H_BLANK; i++) exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, k));
    end
    for (int i = 0; i < VBACK_CYC - 1; i++) exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, k));
    exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, k));
  endtask

  task automatic start_frame();
    logic [1:0]  pat;
    logic [15:0] sol;
    pat = (fidx < 4) ? 2'(fidx) : 2'($urandom_range(0, 3));
    sol = 16'($urandom);
    pattern_sel = pat;
    solid_rgb   = sol;
    push_frame(fidx, pat, sol);
  endtask

  task automatic begin_from_idle();
    exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, fidx));
    enable = 1'b1;
    start_frame();
  endtask

  task automatic run_frame(input bit stop);
    int mid;
    bit glitch, done;
    mid    = $urandom_range(2 + VSYNC_CYC + VFRONT_CYC, FRAME_LEN - 10);
    glitch = !stop && ($urandom_range(0, 1) == 1);
    done   = 1'b0;
    for (int t = 1; t <= FRAME_LEN + 20 && !done; t++) begin
      @(posedge pclk); #1;
      if (t == mid) begin
        pattern_sel = 2'($urandom);
        solid_rgb   = 16'($urandom);
        if (stop || glitch) enable = 1'b0;
      end
      if (glitch && t == mid + 3) enable = 1'b1;
      if (frame_done) done = 1'b1;
    end
    if (!done) to_flag = 1'b1;
    fidx++;
    if (!stop) start_frame();
  endtask

  initial begin : monitor
    exp_t e;
    logic [7:0] idle_fcnt;
    bit to_seen;
    int cyc;
    idle_fcnt = 8'd0;
    to_seen   = 1'b0;
    cyc       = 0;
    forever begin
      @(negedge pclk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        idle_fcnt = 8'd0;
        n_tests++;
        if ({vsync, href, d, frame_done, frame_cnt} != 19'd0) begin
          n_fail++;
          $display("FAIL reset cycle %0d: got vs=%0b hr=%0b d=%02h fd=%0b fc=%0d, want all zero",
                   cyc, vsync, href, d, frame_done, frame_cnt);
        end
      end else begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = mk(1'b0, 1'b0, 8'h00, 1'b0, int'(idle_fcnt));
        n_tests++;
        if ({vsync, href, d, frame_done, frame_cnt} != e) begin
          n_fail++;
          $display("FAIL output cycle %0d: got vs=%0b hr=%0b d=%02h fd=%0b fc=%0d, want vs=%0b hr=%0b d=%02h fd=%0b fc=%0d",
                   cyc, vsync, href, d, frame_done, frame_cnt, e.vs, e.hr, e.d, e.fd, e.fc);
        end
        if (e.fd) idle_fcnt = e.fc + 8'd1;
      end
      if (to_flag && !to_seen) begin
        to_seen = 1'b1;
        n_tests++;
        n_fail++;
        $display("FAIL frame_done timeout: got none within %0d cycles, want one at cycle %0d", FRAME_LEN + 20, FRAME_LEN);
      end
    end
  end

  initial begin : stimulus
    bit stop;
    rst_n = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 16'h0000;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge pclk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge pclk);
    #1;
    begin_from_idle();
    for (int f = 0; f < 10; f++) begin
      stop = (f == 9) || ($urandom_range(0, 3) == 0);
      run_frame(stop);
      if (stop && f < 9) begin
        repeat ($urandom_range(3, 30)) @(posedge pclk);
        #1;
        begin_from_idle();
      end
    end

    // Asynchronous reset in the middle of an active line, then a long disabled idle.
    repeat (5) @(posedge pclk);
    #1;
    begin_from_idle();
    for (int t = 0; t < 200 && !href; t++) begin
      @(posedge pclk); #1;
    end
    repeat (3) @(posedge pclk);
    #3 rst_n = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    enable = 1'b0;
    rst_n  = 1'b1;
    fidx   = 0;
    repeat (1000) @(posedge pclk);
    #1;
    begin_from_idle();
    run_frame(1'b1);
    repeat (10) @(posedge pclk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
